// File: rtl/seg_scan_595.sv
// Scanning driver for chained 74HC595 seven-segment boards: 16-bit frame per digit, double-buffered data.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_595 #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 150
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] dat,
  input  logic [NUM_DIGITS-1:0]   dat_en,
  input  logic [NUM_DIGITS-1:0]   dot_en,
  input  logic                    upd,
  output logic                    seg_sck,
  output logic                    seg_din,
  output logic                    seg_rck,
  output logic                    frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_LATCH_H = 3'd3;
  localparam logic [2:0] S_LATCH_L = 3'd4;

  logic [DIV_W-1:0]        r_div;
  logic [2:0]              r_state;
  logic [4:0]              r_bit;
  logic [2:0]              r_idx;
  logic [15:0]             r_word;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_st_dat, r_sh_dat;
  logic [NUM_DIGITS-1:0]   r_st_en, r_sh_en, r_st_dot, r_sh_dot;

  logic                    w_tick, w_copy;
  logic [4*NUM_DIGITS-1:0] w_src_dat;
  logic [NUM_DIGITS-1:0]   w_src_en, w_src_dot;
  logic [3:0]              w_code;
  logic                    w_en, w_dot, w_blk;
  logic [7:0]              w_sel;
  logic [15:0]             w_word;

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h40;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  assign w_tick = (r_div == DIV_MAX);
  // The digit-0 word of a refreshed frame must already show the staged data.
  assign w_copy    = w_tick && (r_state == S_LOAD) && (r_idx == 3'd0) && r_pend;
  assign w_src_dat = w_copy ? r_st_dat : r_sh_dat;
  assign w_src_en  = w_copy ? r_st_en  : r_sh_en;
  assign w_src_dot = w_copy ? r_st_dot : r_sh_dot;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] r_blank, w_blank_nxt;

  always_comb begin
    logic v_run;
    v_run       = 1'b1;
    w_blank_nxt = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (v_run && w_src_en[i] && (w_src_dat[4*i +: 4] == 4'h0) && !w_src_dot[i])
        w_blank_nxt[i] = 1'b1;
      else
        v_run = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_blank <= '0;
    else if (w_tick && (r_state == S_LOAD) && (r_idx == 3'd0))
      r_blank <= w_blank_nxt;
  end
`endif

  always_comb begin
    w_code = 4'h0;
    w_en   = 1'b0;
    w_dot  = 1'b0;
    w_blk  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == 3'(i)) begin
        w_code = w_src_dat[4*i +: 4];
        w_en   = w_src_en[i];
        w_dot  = w_src_dot[i];
`ifdef SEG_SCAN_LZ_BLANK_EN
        w_blk  = r_blank[i];
`endif
      end
    end
    w_sel  = (w_en && !w_blk) ? ~(8'h01 << r_idx) : 8'hFF;
    w_word = {w_dot, seg7(w_code), w_sel};
  end

  // Staging holds the most recent strobe until the next frame boundary.
  always_ff @(posedge clk) begin
    if (upd) begin
      r_st_dat <= dat;
      r_st_en  <= dat_en;
      r_st_dot <= dot_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_state    <= S_IDLE;
      r_bit      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_pend     <= 1'b0;
      r_sh_dat   <= '0;
      r_sh_en    <= '0;
      r_sh_dot   <= '0;
      seg_sck    <= 1'b0;
      seg_din    <= 1'b0;
      seg_rck    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      r_div      <= w_tick ? '0 : r_div + 1'b1;
      if (upd)
        r_pend <= 1'b1;
      if (w_tick) begin
        case (r_state)
          S_IDLE: r_state <= S_LOAD;
          S_LOAD: begin
            r_word  <= w_word;
            r_bit   <= '0;
            r_state <= S_SHIFT;
            if (w_copy) begin
              r_sh_dat <= r_st_dat;
              r_sh_en  <= r_st_en;
              r_sh_dot <= r_st_dot;
              if (!upd)
                r_pend <= 1'b0;
            end
          end
          // Data only moves on the falling half so it is settled at every rising sck.
          S_SHIFT: begin
            if (!r_bit[0]) begin
              seg_sck <= 1'b0;
              seg_din <= r_word[4'd15 - r_bit[4:1]];
            end else begin
              seg_sck <= 1'b1;
            end
            r_bit <= r_bit + 5'd1;
            if (r_bit == 5'd31)
              r_state <= S_LATCH_H;
          end
          S_LATCH_H: begin
            seg_rck <= 1'b1;
            r_state <= S_LATCH_L;
          end
          S_LATCH_L: begin
            seg_rck <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_idx      <= '0;
              frame_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
            r_state <= S_LOAD;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_595.sv
// Directed bench for seg_scan_595 (NUM_DIGITS=8, CLK_DIV=2) with a 74HC595 chain model on the serial pins.
module tb_seg_scan_595;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dat = '0;
  logic [7:0]  dat_en = '0;
  logic [7:0]  dot_en = '0;
  logic        upd = 1'b0;
  logic        seg_sck, seg_din, seg_rck, frame_done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int r_rel      = 0;

  logic [15:0] sr = '0;
  logic        prev_sck = 1'b0;
  logic        prev_rck = 1'b0;
  logic [15:0] w_q[$];
  int          t_q[$];

  seg_scan_595 #(.NUM_DIGITS(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .dat(dat), .dat_en(dat_en), .dot_en(dot_en), .upd(upd),
    .seg_sck(seg_sck), .seg_din(seg_din), .seg_rck(seg_rck), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board model: shift on rising sck, latch the 16-bit chain on rising rck.
  always @(negedge clk) begin
    prev_sck <= seg_sck;
    prev_rck <= seg_rck;
    if (seg_sck && !prev_sck) sr <= {sr[14:0], seg_din};
    if (seg_rck && !prev_rck) begin
      w_q.push_back(sr);
      t_q.push_back(cyc);
    end
  end

  task automatic clear_q();
    w_q.delete();
    t_q.delete();
  endtask

  task automatic wait_fd(input int budget, output int t);
    t = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    compared++;
    if (t < 0) begin
      mismatched++;
      $display("FAIL frame_done_wait: got no pulse, required one within %0d clk", budget);
    end
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int k = 0; k < budget && w_q.size() < n; k++) @(negedge clk);
    compared++;
    if (w_q.size() < n) begin
      mismatched++;
      $display("FAIL word_wait: got %0d words, required %0d", w_q.size(), n);
    end
  endtask

  task automatic pulse_upd(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    @(negedge clk);
    dat = d; dat_en = e; dot_en = p; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    compared += 4;
    if (seg_sck !== 1'b0)    begin mismatched++; $display("FAIL rst_sck: got %b need 0", seg_sck); end
    if (seg_din !== 1'b0)    begin mismatched++; $display("FAIL rst_din: got %b need 0", seg_din); end
    if (seg_rck !== 1'b0)    begin mismatched++; $display("FAIL rst_rck: got %b need 0", seg_rck); end
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL rst_fd: got %b need 0", frame_done); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r_rel = cyc;
    clear_q();
  endtask

  task automatic test_idle();
    int prev, t1, t2;
    wait_words(8, 1000);
    prev = r_rel;
    for (int i = 0; i < 8; i++) begin
      compared += 2;
      if (w_q[i] !== 16'h3FFF) begin
        mismatched++; $display("FAIL idle_word%0d: got %h need 3fff", i, w_q[i]);
      end
      if (t_q[i] - prev !== 70) begin
        mismatched++; $display("FAIL idle_rck_gap%0d: got %0d need 70", i, t_q[i] - prev);
      end
      prev = t_q[i];
    end
    wait_fd(1000, t1);
    wait_fd(1000, t2);
    compared += 2;
    if (t1 - r_rel !== 562) begin mismatched++; $display("FAIL idle_fd_first: got %0d need 562", t1 - r_rel); end
    if (t2 - t1 !== 560)    begin mismatched++; $display("FAIL idle_fd_period: got %0d need 560", t2 - t1); end
  endtask

  task automatic test_update();
    logic [15:0] exp [8];
    int t;
    exp = '{16'h3FFE, 16'h06FD, 16'h5BFB, 16'h4FF7, 16'h66EF, 16'h6DDF, 16'h7DBF, 16'h077F};
    repeat (200) @(negedge clk);
    pulse_upd(32'h76543210, 8'hFF, 8'h00);
    wait_fd(1000, t);
    clear_q();
    wait_words(8, 1000);
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (w_q[i] !== exp[i]) begin
        mismatched++; $display("FAIL upd_word%0d: got %h need %h", i, w_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_mid_frame();
    int t;
    wait_fd(1000, t);
    clear_q();
    repeat (200) @(negedge clk);
    pulse_upd(32'h76549210, 8'hFF, 8'h00);
    wait_words(8, 1000);
    compared += 2;
    if (w_q[2] !== 16'h5BFB) begin mismatched++; $display("FAIL mid_old_d2: got %h need 5bfb", w_q[2]); end
    if (w_q[3] !== 16'h4FF7) begin mismatched++; $display("FAIL mid_old_d3: got %h need 4ff7", w_q[3]); end
    wait_fd(1000, t);
    clear_q();
    wait_words(8, 1000);
    compared += 2;
    if (w_q[2] !== 16'h5BFB) begin mismatched++; $display("FAIL mid_new_d2: got %h need 5bfb", w_q[2]); end
    if (w_q[3] !== 16'h6FF7) begin mismatched++; $display("FAIL mid_new_d3: got %h need 6ff7", w_q[3]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [8];
    int t;
    exp = '{16'hF1FE, 16'h79FD, 16'hDEFB, 16'h39F7, 16'h7CEF, 16'h40FF, 16'h6FBF, 16'h7F7F};
    wait_fd(1000, t);
    repeat (100) @(negedge clk);
    pulse_upd(32'h11111111, 8'hFF, 8'h00);
    repeat (150) @(negedge clk);
    pulse_upd(32'h89ABCDEF, 8'hDF, 8'h05);
    wait_fd(1000, t);
    clear_q();
    wait_words(8, 1000);
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (w_q[i] !== exp[i]) begin
        mismatched++; $display("FAIL b2b_word%0d: got %h need %h", i, w_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_blank_pattern();
    logic [15:0] exp [8];
    int t;
`ifdef SEG_SCAN_LZ_BLANK_EN
    exp = '{16'h3FFE, 16'h5BFD, 16'h06FB, 16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF};
`else
    exp = '{16'h3FFE, 16'h5BFD, 16'h06FB, 16'h3FF7, 16'h3FEF, 16'h3FDF, 16'h3FBF, 16'h3F7F};
`endif
    wait_fd(1000, t);
    repeat (100) @(negedge clk);
    pulse_upd(32'h00000120, 8'hFF, 8'h00);
    wait_fd(1000, t);
    clear_q();
    wait_words(8, 1000);
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (w_q[i] !== exp[i]) begin
        mismatched++; $display("FAIL lz_word%0d: got %h need %h", i, w_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  t;
    bit  hit = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (seg_sck === 1'b1 && seg_din === 1'b1 && seg_rck === 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
    compared++;
    if (!hit) begin mismatched++; $display("FAIL rmid_shift_wait: got no sck=din=1, required within 1000 clk"); end
    #1 rst = 1'b1;
    #1;
    compared += 4;
    if (seg_sck !== 1'b0)    begin mismatched++; $display("FAIL rmid_sck: got %b need 0", seg_sck); end
    if (seg_din !== 1'b0)    begin mismatched++; $display("FAIL rmid_din: got %b need 0", seg_din); end
    if (seg_rck !== 1'b0)    begin mismatched++; $display("FAIL rmid_rck: got %b need 0", seg_rck); end
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL rmid_fd: got %b need 0", frame_done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r_rel = cyc;
    clear_q();
    wait_words(1, 200);
    compared += 2;
    if (w_q[0] !== 16'h3FFF)    begin mismatched++; $display("FAIL rmid_word0: got %h need 3fff", w_q[0]); end
    if (t_q[0] - r_rel !== 70)  begin mismatched++; $display("FAIL rmid_rck_time: got %0d need 70", t_q[0] - r_rel); end
    wait_fd(1000, t);
    compared++;
    if (t - r_rel !== 562) begin mismatched++; $display("FAIL rmid_fd_time: got %0d need 562", t - r_rel); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_update();
    test_mid_frame();
    test_back_to_back();
    test_blank_pattern();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before 2000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
